// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream stage.
package fifo_stream_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int WORD_CNT_W = 16;

  typedef logic [1:0] occ_t;

  // True when one more pop can be issued without overrunning the 2-entry
  // buffer, counting words already buffered, in flight, and leaving now.
  function automatic logic has_credit(occ_t occ, logic inflight, logic pop);
    logic [2:0] fill;
    fill = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    return (fill < 3'd2);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO drain stage.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = fifo_stream_pkg::DATA_WIDTH
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: ring of two words with 1-bit head/tail pointers.
// The caller guarantees no write when full and no read when empty.
module fifo_rd_skid
  import fifo_stream_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  output logic [DW-1:0] rd_data,
  output occ_t          occ
);

  logic [DW-1:0] mem [2];
  logic          head;
  logic          tail;

  // Storage, pointers and occupancy; simultaneous wr and rd leave occ unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= '0;
    end else begin
      if (wr) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (rd) head <= ~head;
      occ <= occ_t'({1'b0, occ} + {2'b0, wr} - {2'b0, rd});
    end
  end

  // Head entry is always presented; its validity is occ != 0.
  always_comb rd_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: pops a 1-cycle-latency FIFO and re-presents the
// words as a full-throughput valid/ready stream with packet framing,
// a delivered-word counter and a sticky underflow flag.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_stream_pkg::DATA_WIDTH,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  fifo_rd_stream_if.master      m,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  proto_err
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic              pop;
  logic              inflight;
  logic [BEAT_W-1:0] beat;
  occ_t              occ;
  logic              valid;

  fifo_rd_skid #(.DW(DATA_WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (inflight),
    .wr_data (fifo_dout),
    .rd      (pop),
    .rd_data (m.m_data),
    .occ     (occ)
  );

  // Stream outputs come straight from registered state, never from m_ready.
  always_comb begin
    valid     = (occ != 2'd0);
    m.m_valid = valid;
    m.m_last  = valid & (beat == BEAT_LAST);
    pop       = valid & m.m_ready;
  end

  // Pop only when the buffer has room for everything already committed;
  // rst_n gates the pop so nothing leaves the FIFO while in reset.
  always_comb fifo_rd_en = rst_n & ~fifo_empty & has_credit(occ, inflight, pop);

  // A pop issued this cycle lands in the buffer next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  // Position within the current packet, advanced per delivered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   beat <= '0;
    else if (pop) beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
  end

  // Delivered-word counter, free-running modulo 2^WORD_CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 1'b1;
  end

  // Sticky record that the FIFO ever reported an underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              proto_err <= 1'b0;
    else if (fifo_underflow) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural 1-cycle-latency FIFO, pop monitor,
// directed scenarios with hand-computed expectations.
module tb_fifo_rd_stream;
  import fifo_stream_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic [15:0]   word_cnt;
  logic          proto_err;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_dout      (fifo_dout),
    .fifo_rd_en     (fifo_rd_en),
    .m              (s.master),
    .word_cnt       (word_cnt),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } rec_t;

  logic [DW-1:0] q[$];
  rec_t          out_q[$];
  logic          inf_mode = 1'b0;
  logic [DW-1:0] inf_cnt = '0;
  logic          uf_seen = 1'b0;
  int            cyc = 0;
  int            first_rd = -1;
  int            rd_cnt = 0;
  int            vld_cnt = 0;
  int            n_chk = 0;
  int            n_err = 0;

  // FIFO model: data registered one cycle after the pop
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_dout <= '0;
    end else if (fifo_rd_en) begin
      if (inf_mode) begin
        fifo_dout <= inf_cnt;
        inf_cnt   <= inf_cnt + 1'b1;
      end else if (q.size() == 0) begin
        uf_seen <= 1'b1;
      end else begin
        fifo_dout  <= q.pop_front();
        fifo_empty <= (q.size() == 0);
      end
    end
  end

  // Monitor: pre-edge values of handshake signals
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (first_rd < 0) first_rd <= cyc;
    end
    if (s.m_valid) vld_cnt <= vld_cnt + 1;
    if (s.m_valid && s.m_ready && !inf_mode)
      out_q.push_back('{s.m_data, s.m_last, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic assert_rst();
    @(negedge clk);
    rst_n = 1'b0;
    s.m_ready = 1'b0;
    q.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    out_q.delete();
    first_rd = -1;
    rd_cnt = 0;
    vld_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_outs(input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("out_count", out_q.size(), n);
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    int bad;
    int k;
    s.m_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_valid", s.m_valid, 0);
    chk("rst_last", s.m_last, 0);
    chk("rst_data", s.m_data, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_rden", fifo_rd_en, 0);

    // Reset then stream 1..8
    assert_rst();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    release_rst();
    s.m_ready = 1'b1;
    wait_outs(8, 40);
    if (out_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("s_data%0d", i), out_q[i].data, i + 1);
        chk($sformatf("s_last%0d", i), out_q[i].last, (i == 3 || i == 7) ? 1 : 0);
      end
      chk("s_lat", out_q[0].cyc, first_rd + 2);
      chk("s_thru", out_q[7].cyc - out_q[0].cyc, 7);
    end
    chk("s_cnt", word_cnt, 8);

    // Backpressure
    assert_rst();
    for (int i = 1; i <= 6; i++) push(DW'(i));
    release_rst();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s.m_valid && s.m_data !== 16'h0001) bad++;
    end
    chk("bp_pops", rd_cnt, 2);
    chk("bp_hold", bad, 0);
    chk("bp_valid", s.m_valid, 1);
    s.m_ready = 1'b1;
    wait_outs(6, 40);
    repeat (5) @(negedge clk);
    chk("bp_nodup", out_q.size(), 6);
    bad = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i].data !== DW'(i + 1)) bad++;
    chk("bp_order", bad, 0);

    // Random ready
    assert_rst();
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      exp_q.push_back(DW'($urandom));
      push(exp_q[i]);
    end
    release_rst();
    k = 0;
    while (out_q.size() < 200 && k < 3000) begin
      s.m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    chk("rnd_count", out_q.size(), 200);
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 200; i++)
      if (out_q[i].data !== exp_q[i]) bad++;
    chk("rnd_order", bad, 0);
    chk("rnd_uflow", uf_seen, 0);
    chk("rnd_perr", proto_err, 0);
    chk("rnd_cnt", word_cnt, 200);

    // Underflow -> sticky proto_err
    @(negedge clk);
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    chk("err_set", proto_err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", proto_err, 1);

    // Empty boundary
    assert_rst();
    release_rst();
    s.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("emp_idle", rd_cnt, 0);
    chk("emp_perr_clr", proto_err, 0);
    push(16'hBEEF);
    repeat (6) @(negedge clk);
    chk("emp_rd", rd_cnt, 1);
    chk("emp_vld", vld_cnt, 1);
    chk("emp_outs", out_q.size(), 1);
    if (out_q.size() > 0) chk("emp_data", out_q[0].data, 16'hBEEF);

    // Reset mid-packet with a pop in flight
    assert_rst();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    release_rst();
    s.m_ready = 1'b1;
    wait_outs(2, 20);
    chk("mid_pre_cnt", word_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", s.m_valid, 0);
    chk("mid_last", s.m_last, 0);
    chk("mid_data", s.m_data, 0);
    chk("mid_cnt", word_cnt, 0);
    chk("mid_rden", fifo_rd_en, 0);
    s.m_ready = 1'b0;
    q.delete();
    fifo_empty = 1'b1;
    for (int i = 0; i < 8; i++) push(DW'(16'h11 + i));
    release_rst();
    s.m_ready = 1'b1;
    wait_outs(8, 40);
    if (out_q.size() == 8) begin
      chk("mid_first", out_q[0].data, 16'h0011);
      chk("mid_nolast", {out_q[0].last, out_q[1].last, out_q[2].last}, 0);
      chk("mid_last4", out_q[3].last, 1);
      chk("mid_last8", out_q[7].last, 1);
    end

    // word_cnt wrap
    assert_rst();
    release_rst();
    inf_mode = 1'b1;
    fifo_empty = 1'b0;
    s.m_ready = 1'b1;
    k = 0;
    while (word_cnt !== 16'hFFFF && k < 70000) begin
      @(negedge clk);
      k++;
    end
    s.m_ready = 1'b0;
    chk("wrap_pre", word_cnt, 16'hFFFF);
    chk("wrap_valid", s.m_valid, 1);
    s.m_ready = 1'b1;
    @(negedge clk);
    s.m_ready = 1'b0;
    chk("wrap_zero", word_cnt, 16'h0000);
    inf_mode = 1'b0;
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage sitting directly downstream of the synchronous FIFO. It pops words through the FIFO's `rd_en`/`data_out` port, where data arrives one cycle after the pop, and re-presents them as a valid/ready stream with full throughput. It tags every PKT_LEN-th word with `m_last`, counts delivered words, and flags any FIFO underflow as a sticky protocol error.

## Interface
- `DATA_WIDTH`, 16: width of FIFO words and of `m_data`.
- `PKT_LEN`, 4: words per packet; `m_last` marks the final word of each packet. Legal range 1..256.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag; combinational from the FIFO count.
- `fifo_underflow`  in  1  FIFO underflow flag, registered by the FIFO.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop.
- `fifo_rd_en`  out  1  pop request to the FIFO; combinational.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DATA_WIDTH  output word, head of the skid buffer.
- `m_last`  out  1  final word of the current packet.
- `word_cnt`  out  16  total words delivered; wraps modulo 2^16.
- `proto_err`  out  1  sticky; set on any `fifo_underflow` pulse.

## Operation
- Internal state:
  - 2-entry skid buffer (`occ` ∈ {0,1,2}, head/tail 1-bit pointers).
  - `inflight` bit: a pop was issued last cycle and its data is arriving this cycle.
  - Beat counter `beat` (0..PKT_LEN-1).
  - `word_cnt` and `proto_err`.
- Pop condition:
  - `pop = m_valid & m_ready`.
  - `fifo_rd_en = !fifo_empty & ((occ + inflight - pop) < 2)`.
  - The buffer can therefore never overflow.
- Capture: when `inflight`=1, write `fifo_dout` at the tail, then advance the tail.
- Buffer occupancy:
  - `m_valid = (occ != 0)`; `m_data` = entry at the head.
  - On `pop`, advance the head.
  - `occ` next value = `occ + inflight - pop` (capture and pop in the same cycle keep `occ` unchanged).
  - `inflight` next value = `fifo_rd_en`.
- Packet framing:
  - `m_last = m_valid & (beat == PKT_LEN-1)`.
  - On `pop`, `beat` increments and wraps to 0 after PKT_LEN-1.
  - With PKT_LEN=1, `m_last` equals `m_valid`.
- `word_cnt` increments on every `pop` and wraps from 0xFFFF to 0.
- `proto_err` sets when `fifo_underflow`=1 and stays set until reset. A correct system never asserts underflow, because `fifo_rd_en` is gated by `!fifo_empty`.
- Stream rules:
  - Once `m_valid` is asserted, `m_valid`, `m_data` and `m_last` stay stable until `pop`.
  - `m_valid` never depends combinationally on `m_ready`.
- Reset (`rst_n` low, at any time, including mid-packet or with a pop in flight):
  - Immediately: `occ`=0, `inflight`=0, `beat`=0, `word_cnt`=0, `proto_err`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
  - `fifo_rd_en` is forced to 0 while `rst_n` is low.
  - Data popped in the cycle before reset is discarded. The FIFO resets on the same `rst_n`, so no word is orphaned.

## Timing
- Latency from FIFO non-empty to `m_valid`: 2 cycles.
  - Cycle N: `fifo_rd_en`=1.
  - Edge N+1: `inflight` is set and the FIFO registers `fifo_dout`.
  - Edge N+2: data is captured and `m_valid`=1.
- Throughput is 1 word/cycle with `m_ready` held at 1 and the FIFO non-empty.
- Backpressure: with `m_ready`=0, at most 2 words are buffered. `fifo_rd_en` deasserts once `occ + inflight` reaches 2.
- `fifo_rd_en` is combinational from `fifo_empty`, `m_ready` and internal registers. It has no path from `fifo_dout`.

## Structure
- Package `fifo_stream_pkg`:
  - `DATA_WIDTH` default.
  - `occ_t` (2-bit) typedef.
  - `WORD_CNT_W = 16` constant.
- Sub-module `fifo_rd_skid`: the 2-entry buffer with its head/tail/`occ` logic, `wr`/`rd` strobes and `occ` output.
- The top level holds the pop/credit logic, `inflight`, `beat`, `word_cnt` and `proto_err`.

## Test plan
- **Reset then stream:** reset, FIFO preloaded with 0x0001..0x0008, `m_ready`=1.
  - Words 1..8 appear on consecutive cycles starting 2 cycles after the first `fifo_rd_en`.
  - `m_last` is asserted on 0x0004 and 0x0008.
  - `word_cnt` ends at 8.
- **Backpressure:** FIFO holding 6 words, `m_ready`=0 for 10 cycles, then 1.
  - Exactly 2 pops are issued while `m_ready`=0.
  - `m_data` holds 0x0001 throughout.
  - After release, all 6 words are delivered in order with none lost or duplicated.
- **Random ready:** 200 random words, `m_ready` toggled at 50%.
  - Output order matches input order.
  - `fifo_underflow` never asserts.
  - `proto_err`=0 and `word_cnt`=200.
- **Empty boundary:** single word written into an empty FIFO.
  - Exactly one `fifo_rd_en` pulse.
  - `m_valid` pulses for one word.
  - No further pop while `fifo_empty`=1.
- **Reset mid-packet:** assert `rst_n` low after word 2 of a packet, with `inflight`=1.
  - All outputs go to 0 immediately.
  - After release, the next delivered word has `beat` 0, so `m_last` first asserts on the 4th word.
- **Error and wrap:**
  - Force `fifo_underflow`=1 for 1 cycle: `proto_err` rises and stays 1.
  - Preload `word_cnt` to 0xFFFF (via 65535 pops), then pop once more: `word_cnt`=0x0000.
